instr_sequencer: RTL and testbench

//  Multi-cycle fetch/decode/execute controller for the 16-bit GPR datapath.

---
 rtl/instr_sequencer_if.sv | 26 ++
 rtl/instr_sequencer.sv | 165 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Program-memory fetch channel and datapath control bundle of the instruction sequencer.
// The master side is the sequencer; the slave side is program memory plus the GPR datapath.
interface instr_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_valid;
    logic [31:0]       ir;
    logic              exec_busy;
    logic              gpr_wr_en;
    logic              halted;
    logic              illegal_op;
    logic [15:0]       retired;

    modport master (
        output imem_req, imem_addr, ir, exec_busy, gpr_wr_en, halted, illegal_op, retired,
        input  imem_rdata, imem_valid
    );

    modport slave (
        input  imem_req, imem_addr, ir, exec_busy, gpr_wr_en, halted, illegal_op, retired,
        output imem_rdata, imem_valid
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit GPR datapath.
// Fetches one 32-bit word at a time into IR and strobes the register write once per instruction.
module instr_sequencer #(
    parameter int         ADDR_W     = 8,
    parameter int         MUL_CYCLES = 3,
    parameter logic [4:0] HALT_OP    = 5'b11111
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              start,
    instr_sequencer_if.master bus
);
    localparam logic [4:0] OP_MUL      = 5'b00100;
    localparam logic [4:0] OP_LAST_DEF = 5'b00100;
    localparam logic [3:0] MUL_LAST    = 4'(MUL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir;
    logic [3:0]        cnt;
    logic [15:0]       retired;
    logic              illegal;
    logic [4:0]        opcode;

    logic req, busy, wr, halt_flag;
    logic pc_clear, pc_inc, ir_load, cnt_load, cnt_dec, ill_set, stats_clear;

    function automatic logic op_is_defined(input logic [4:0] op);
        return (op <= OP_LAST_DEF);
    endfunction

    // Remaining EXEC cycles after the first one.
    function automatic logic [3:0] exec_last(input logic [4:0] op);
        return (op == OP_MUL) ? MUL_LAST : 4'd0;
    endfunction

    assign opcode = ir[31:27];

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        req         = 1'b0;
        busy        = 1'b0;
        wr          = 1'b0;
        halt_flag   = 1'b0;
        pc_clear    = 1'b0;
        pc_inc      = 1'b0;
        ir_load     = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        ill_set     = 1'b0;
        stats_clear = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    pc_clear = 1'b1;
                    state_n  = S_FETCH;
                end
            end
            S_FETCH: begin
                req     = 1'b1;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (bus.imem_valid) begin
                    ir_load = 1'b1;
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                // HALT_OP is checked first so it wins even if it overlaps a defined opcode.
                if (opcode == HALT_OP) begin
                    state_n = S_HALT;
                end else if (!op_is_defined(opcode)) begin
                    ill_set = 1'b1;
                    state_n = S_HALT;
                end else begin
                    cnt_load = 1'b1;
                    state_n  = S_EXEC;
                end
            end
            S_EXEC: begin
                busy = 1'b1;
                if (cnt != 4'd0) begin
                    cnt_dec = 1'b1;
                end else begin
                    wr      = 1'b1;
                    pc_inc  = 1'b1;
                    state_n = S_FETCH;
                end
            end
            S_HALT: begin
                halt_flag = 1'b1;
                if (start) begin
                    pc_clear    = 1'b1;
                    stats_clear = 1'b1;
                    state_n     = S_FETCH;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            pc      <= '0;
            ir      <= '0;
            cnt     <= '0;
            retired <= '0;
            illegal <= 1'b0;
        end else begin
            if (pc_clear) begin
                pc <= '0;
            end else if (pc_inc) begin
                pc <= pc + ADDR_W'(1);
            end
            if (ir_load) begin
                ir <= bus.imem_rdata;
            end
            if (cnt_load) begin
                cnt <= exec_last(opcode);
            end else if (cnt_dec) begin
                cnt <= cnt - 4'd1;
            end
            if (stats_clear) begin
                retired <= '0;
                illegal <= 1'b0;
            end else begin
                if (wr) begin
                    retired <= retired + 16'd1;
                end
                if (ill_set) begin
                    illegal <= 1'b1;
                end
            end
        end
    end

    assign bus.imem_req   = req;
    assign bus.imem_addr  = pc;
    assign bus.ir         = ir;
    assign bus.exec_busy  = busy;
    assign bus.gpr_wr_en  = wr;
    assign bus.halted     = halt_flag;
    assign bus.illegal_op = illegal;
    assign bus.retired    = retired;
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: timeline-based reference model checked every cycle,
// directed scenarios with literal timing expectations, then a randomized run.
module tb_instr_sequencer;
    localparam int AW    = 3;
    localparam int MC    = 3;
    localparam int DEPTH = 1 << AW;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic clk = 1'b0;
    logic sys_rst;
    logic start;

    instr_sequencer_if #(.ADDR_W(AW)) bus ();

    instr_sequencer #(
        .ADDR_W    (AW),
        .MUL_CYCLES(MC)
    ) dut (
        .clk    (clk),
        .sys_rst(sys_rst),
        .start  (start),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] mem [DEPTH];

    // Reference model: coarse run mode plus the cycle numbers at which events must occur.
    int          mode;
    int          pc;
    int          ret;
    bit          ill;
    logic [31:0] m_ir;
    int          t_req, t_val, t_dec, t_wr;
    bit          have_exec, pend_halt, pend_ill;

    bit rand_mode   = 0;
    bit req_rst     = 0;
    bit req_start   = 0;
    bit force_stray = 0;
    int fix_lat     = 1;

    int s0       = 0;
    int busy_cnt = 0;
    int q_req_t[$];
    int q_req_a[$];
    int q_wr_t[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic model_reset();
        mode      = M_IDLE;
        pc        = 0;
        ret       = 0;
        ill       = 0;
        m_ir      = '0;
        have_exec = 0;
        pend_halt = 0;
        pend_ill  = 0;
        t_req     = -10;
        t_val     = -10;
        t_dec     = -10;
        t_wr      = -10;
    endtask

    function automatic int pick_lat();
        int r;
        if (fix_lat > 0) return fix_lat;
        r = int'($urandom % 10);
        if (r < 6) return 1;
        if (r < 9) return 2 + int'($urandom % 3);
        return 6;
    endfunction

    task automatic schedule_fetch(input int t);
        t_req     = t;
        t_val     = t + pick_lat();
        have_exec = 0;
        pend_halt = 0;
    endtask

    task automatic rand_prog();
        for (int i = 0; i < DEPTH; i++) begin
            int         r;
            logic [4:0] op;
            r = int'($urandom % 100);
            if (r < 30)      op = 5'd2;
            else if (r < 45) op = 5'd1;
            else if (r < 55) op = 5'd0;
            else if (r < 62) op = 5'd3;
            else if (r < 85) op = 5'd4;
            else if (r < 93) op = 5'd31;
            else             op = 5'(5 + $urandom % 26);
            mem[i] = {op, 27'($urandom)};
        end
    endtask

    task automatic model_update(input bit r, input bit s, input logic [31:0] d);
        if (r) begin
            model_reset();
        end else if (mode == M_IDLE || mode == M_HALT) begin
            if (s) begin
                if (mode == M_HALT) begin
                    ill = 0;
                    ret = 0;
                end
                mode = M_RUN;
                pc   = 0;
                schedule_fetch(cyc + 1);
            end
        end else if (cyc == t_val) begin
            int op;
            m_ir  = d;
            op    = int'(d[31:27]);
            t_dec = cyc + 1;
            if (op <= 4) begin
                have_exec = 1;
                t_wr      = t_dec + ((op == 4) ? MC : 1);
            end else begin
                pend_halt = 1;
                pend_ill  = (op != 31);
            end
        end else if (pend_halt && cyc == t_dec) begin
            mode      = M_HALT;
            pend_halt = 0;
            if (pend_ill) ill = 1;
        end else if (have_exec && cyc == t_wr) begin
            ret = (ret + 1) & 16'hFFFF;
            pc  = (pc + 1) % DEPTH;
            schedule_fetch(cyc + 1);
        end
    endtask

    task automatic check_outputs();
        bit e_req, e_busy, e_wr;
        e_req  = (mode == M_RUN) && (cyc == t_req);
        e_busy = (mode == M_RUN) && have_exec && (cyc > t_dec) && (cyc <= t_wr);
        e_wr   = (mode == M_RUN) && have_exec && (cyc == t_wr);
        chk("imem_req",   32'(bus.imem_req),   32'(e_req));
        chk("imem_addr",  32'(bus.imem_addr),  32'(pc));
        chk("ir",         bus.ir,              m_ir);
        chk("exec_busy",  32'(bus.exec_busy),  32'(e_busy));
        chk("gpr_wr_en",  32'(bus.gpr_wr_en),  32'(e_wr));
        chk("halted",     32'(bus.halted),     32'(mode == M_HALT));
        chk("illegal_op", 32'(bus.illegal_op), 32'(ill));
        chk("retired",    32'(bus.retired),    32'(ret));
        if (bus.imem_req === 1'b1) begin
            q_req_t.push_back(cyc - s0);
            q_req_a.push_back(int'(bus.imem_addr));
        end
        if (bus.gpr_wr_en === 1'b1) q_wr_t.push_back(cyc - s0);
        if (bus.exec_busy === 1'b1) busy_cnt++;
    endtask

    task automatic step();
        bit          rst_now, st_now, v_now, in_win;
        logic [31:0] d_now;
        rst_now   = req_rst || (rand_mode && ($urandom % 400 == 0));
        st_now    = req_start || (rand_mode && ($urandom % 4 == 0));
        req_rst   = 0;
        req_start = 0;
        in_win    = (mode == M_RUN) && (cyc > t_req) && (cyc <= t_val);
        v_now     = 0;
        d_now     = $urandom;
        if (rand_mode && st_now && mode != M_RUN) rand_prog();
        if (mode == M_RUN && cyc == t_val) begin
            v_now = 1;
            d_now = mem[pc];
        end else if (!in_win && (force_stray || (rand_mode && ($urandom % 6 == 0)))) begin
            v_now = 1;
        end
        sys_rst        = rst_now;
        start          = st_now;
        bus.imem_valid = v_now;
        bus.imem_rdata = d_now;
        model_update(rst_now, st_now, d_now);
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic do_reset();
        req_rst = 1;
        step();
    endtask

    task automatic begin_run();
        s0       = cyc;
        busy_cnt = 0;
        q_req_t.delete();
        q_req_a.delete();
        q_wr_t.delete();
        req_start = 1;
        step();
    endtask

    task automatic fill_add();
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000;
    endtask

    initial begin
        sys_rst        = 1'b1;
        start          = 1'b0;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
        model_reset();
        fill_add();
        @(posedge clk);
        #1;
        check_outputs();

        // Single add, one-cycle memory.
        fix_lat = 1;
        do_reset();
        begin_run();
        repeat (6) step();
        chk("s1_req0_t",  32'(at(q_req_t, 0)), 32'd1);
        chk("s1_req0_a",  32'(at(q_req_a, 0)), 32'd0);
        chk("s1_wr_n",    32'(q_wr_t.size()),  32'd1);
        chk("s1_wr0_t",   32'(at(q_wr_t, 0)),  32'd4);
        chk("s1_req1_t",  32'(at(q_req_t, 1)), 32'd5);
        chk("s1_req1_a",  32'(at(q_req_a, 1)), 32'd1);
        chk("s1_retired", 32'(bus.retired),    32'd1);

        // mul occupies MC EXEC cycles with a single strobe on the last one.
        fill_add();
        mem[0] = 32'h2000_0000;
        do_reset();
        begin_run();
        repeat (7) step();
        chk("s2_busy_n",  32'(busy_cnt),       32'd3);
        chk("s2_wr_n",    32'(q_wr_t.size()),  32'd1);
        chk("s2_wr0_t",   32'(at(q_wr_t, 0)),  32'd6);
        chk("s2_req1_t",  32'(at(q_req_t, 1)), 32'd7);
        chk("s2_req1_a",  32'(at(q_req_a, 1)), 32'd1);

        // mov, add, HALT then restart from HALT.
        mem[0] = 32'h0800_0000;
        mem[1] = 32'h1000_0000;
        mem[2] = 32'hF800_0000;
        do_reset();
        begin_run();
        repeat (11) step();
        chk("s3_halted",  32'(bus.halted),     32'd1);
        chk("s3_pc",      32'(bus.imem_addr),  32'd2);
        chk("s3_retired", 32'(bus.retired),    32'd2);
        chk("s3_req2_t",  32'(at(q_req_t, 2)), 32'd9);
        chk("s3_illegal", 32'(bus.illegal_op), 32'd0);
        begin_run();
        chk("s3_rs_req",  32'(bus.imem_req),   32'd1);
        chk("s3_rs_addr", 32'(bus.imem_addr),  32'd0);
        chk("s3_rs_ret",  32'(bus.retired),    32'd0);

        // Undefined opcode 00101.
        mem[0] = 32'h2800_0000;
        do_reset();
        begin_run();
        repeat (5) step();
        chk("s4_illegal", 32'(bus.illegal_op), 32'd1);
        chk("s4_halted",  32'(bus.halted),     32'd1);
        chk("s4_retired", 32'(bus.retired),    32'd0);
        chk("s4_wr_n",    32'(q_wr_t.size()),  32'd0);
        begin_run();
        chk("s4_ill_clr", 32'(bus.illegal_op), 32'd0);

        // PC wrap over all 2**AW words.
        fill_add();
        do_reset();
        begin_run();
        repeat (32) step();
        chk("s5_req_n",   32'(q_req_t.size()), 32'(DEPTH + 1));
        chk("s5_last_a",  32'(at(q_req_a, DEPTH - 1)), 32'(DEPTH - 1));
        chk("s5_wrap_a",  32'(at(q_req_a, DEPTH)), 32'd0);
        chk("s5_wrap_t",  32'(at(q_req_t, DEPTH)), 32'(1 + 4 * DEPTH));
        chk("s5_retired", 32'(bus.retired),    32'(DEPTH));

        // Five-cycle memory latency.
        fix_lat = 5;
        do_reset();
        begin_run();
        repeat (9) step();
        chk("s5d_wr0_t",  32'(at(q_wr_t, 0)),  32'd8);
        chk("s5d_req1_t", 32'(at(q_req_t, 1)), 32'd9);
        chk("s5d_ir",     bus.ir,              32'h1000_0000);

        // Reset during mul EXEC, then during WAIT, with stray valids afterwards.
        fix_lat = 1;
        mem[0] = 32'h2000_0000;
        do_reset();
        begin_run();
        repeat (4) step();
        chk("s6_busy",    32'(bus.exec_busy),  32'd1);
        do_reset();
        chk("s6_r_busy",  32'(bus.exec_busy),  32'd0);
        chk("s6_r_wr",    32'(bus.gpr_wr_en),  32'd0);
        chk("s6_r_ir",    bus.ir,              32'd0);
        chk("s6_r_addr",  32'(bus.imem_addr),  32'd0);
        force_stray = 1;
        repeat (3) step();
        force_stray = 0;
        chk("s6_stray_ir", bus.ir,             32'd0);
        fix_lat = 4;
        begin_run();
        repeat (2) step();
        do_reset();
        force_stray = 1;
        repeat (4) step();
        force_stray = 0;
        chk("s6w_ir",     bus.ir,              32'd0);
        chk("s6w_wr_n",   32'(q_wr_t.size()),  32'd0);
        chk("s6w_ret",    32'(bus.retired),    32'd0);

        // Randomized run.
        fix_lat   = 0;
        rand_mode = 1;
        rand_prog();
        do_reset();
        repeat (20000) step();
        rand_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
